// File: rtl/freq_count_latch.sv
// Frequency-meter datapath: synchronised BCD edge counter with a latched display register.
// Optional FREQ_BLANK_ZERO_EN: blanks leading-zero digits (4'hF) of count_bcd at capture.
module freq_count_latch #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig_in,
  input  logic                  enable,
  input  logic                  clear_n,
  input  logic                  latch,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  overflow,
  output logic                  data_valid
);

  localparam int W = 4 * DIGITS;

  // [0] and [1] are the synchroniser stages, [2] is the edge-detect history flop.
  logic [2:0]   r_sig_sync, r_en_sync, r_clr_sync, r_lat_sync;
  logic [W-1:0] r_count;
  logic         r_ovf;

  logic         w_sig_rise, w_lat_rise, w_en, w_clr_n;
  logic [W-1:0] w_count_inc, w_capture;
  logic         w_inc_carry;

  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return {carry, res};
  endfunction

`ifdef FREQ_BLANK_ZERO_EN
  // Digits above the most significant non-zero digit become the blank code; digit 0 always shows.
  function automatic logic [W-1:0] blank_lz(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         lead;
    res  = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) res[4*i +: 4] = 4'hF;
      else                             lead = 1'b0;
    end
    return res;
  endfunction

  assign w_capture = blank_lz(r_count);
`else
  assign w_capture = r_count;
`endif

  assign w_sig_rise = r_sig_sync[1] & ~r_sig_sync[2];
  assign w_lat_rise = r_lat_sync[1] & ~r_lat_sync[2];
  assign w_en       = r_en_sync[1];
  assign w_clr_n    = r_clr_sync[1];

  assign {w_inc_carry, w_count_inc} = bcd_inc(r_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig_sync <= 3'b000;
      r_en_sync  <= 3'b000;
      r_clr_sync <= 3'b000;
      // Latch idles high, so its history resets high to avoid a spurious capture.
      r_lat_sync <= 3'b111;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      count_bcd  <= '0;
      overflow   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      r_sig_sync <= {r_sig_sync[1:0], sig_in};
      r_en_sync  <= {r_en_sync[1:0],  enable};
      r_clr_sync <= {r_clr_sync[1:0], clear_n};
      r_lat_sync <= {r_lat_sync[1:0], latch};

      if (!w_clr_n) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_en && w_sig_rise) begin
        r_count <= w_count_inc;
        r_ovf   <= r_ovf | w_inc_carry;
      end

      // NOTE: non-blocking assignments mean the capture below sees the counter
      // value from before this cycle's clear or increment.
      data_valid <= w_lat_rise;
      if (w_lat_rise) begin
        count_bcd <= w_capture;
        overflow  <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_freq_count_latch.sv
// Self-checking bench for freq_count_latch: directed scenarios plus randomized windows
// checked against an integer pulse-count model.
module tb_freq_count_latch;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MOD    = 10 ** DIGITS;

  logic         clk = 1'b0;
  logic         reset, sig_in, enable, clear_n, latch;
  logic [W-1:0] count_bcd;
  logic         overflow, data_valid;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  freq_count_latch #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .enable     (enable),
    .clear_n    (clear_n),
    .latch      (latch),
    .count_bcd  (count_bcd),
    .overflow   (overflow),
    .data_valid (data_valid)
  );

  // Expected display word for a count n, built digit by digit with decimal arithmetic.
  function automatic logic [W-1:0] to_disp(input int n);
    logic [W-1:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef FREQ_BLANK_ZERO_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (n < 10 ** i) r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulses(input int n, input int half);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) sig_in = 1'b1;
      repeat (half - 1) @(negedge clk);
      @(negedge clk) sig_in = 1'b0;
      repeat (half - 1) @(negedge clk);
      if (enable && clear_n) begin
        m_cnt++;
        if (m_cnt == MOD) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk) clear_n = 1'b0;
    repeat (4) @(negedge clk);
    clear_n = 1'b1;
    settle();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Drives latch 1->0->1 (optionally dropping clear_n with the rise) and watches data_valid.
  task automatic capture(input bit with_clear, output logic [W-1:0] got, output logic got_ovf,
                         output int dv_edge, output int dv_cnt);
    @(negedge clk) latch = 1'b0;
    settle();
    @(negedge clk) latch = 1'b1;
    if (with_clear) clear_n = 1'b0;
    dv_edge = -1;
    dv_cnt  = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (data_valid === 1'b1) begin
        dv_cnt++;
        if (dv_edge < 0) dv_edge = e;
      end
    end
    got     = count_bcd;
    got_ovf = overflow;
    if (with_clear) begin
      @(negedge clk) clear_n = 1'b1;
      settle();
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic test_reset();
    int dv_seen;
    sig_in = 1'b0; enable = 1'b0; clear_n = 1'b1; latch = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    reset = 1'b0;
    n_cmp++;
    if (count_bcd !== '0) begin n_err++; $display("FAIL reset_count: got %h expected 0", count_bcd); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    dv_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (data_valid !== 1'b0) dv_seen++;
    end
    n_cmp++;
    if (dv_seen !== 0) begin n_err++; $display("FAIL reset_idle_dv: got %0d pulses expected 0", dv_seen); end
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic test_count_37();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt; logic [W-1:0] exp;
    enable = 1'b1;
    settle();
    pulses(37, 4);
    settle();
    enable = 1'b0;
    settle();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL c37_count: got %h expected %h", got, exp); end
    n_cmp++;
    if (got_ovf !== 1'b0) begin n_err++; $display("FAIL c37_ovf: got %b expected 0", got_ovf); end
    n_cmp++;
    if (dv_edge !== 3) begin n_err++; $display("FAIL c37_dv_edge: got %0d expected 3", dv_edge); end
    n_cmp++;
    if (dv_cnt !== 1) begin n_err++; $display("FAIL c37_dv_count: got %0d expected 1", dv_cnt); end
    // Second capture with no new pulses repeats the held count.
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL c37_recapture: got %h expected %h", got, exp); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt;
    logic [W-1:0] exp; logic exp_ovf;
    do_clear();
    enable = 1'b1;
    settle();
    pulses(10001, 2);
    settle();
    exp = to_disp(m_cnt); exp_ovf = m_ovf;
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL ovf_count: got %h expected %h", got, exp); end
    n_cmp++;
    if (got_ovf !== exp_ovf) begin n_err++; $display("FAIL ovf_flag: got %b expected %b", got_ovf, exp_ovf); end
    do_clear();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL ovf_clr_count: got %h expected %h", got, exp); end
    n_cmp++;
    if (got_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr_flag: got %b expected 0", got_ovf); end
  endtask

  task automatic test_latch_with_clear();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt; logic [W-1:0] exp;
    do_clear();
    enable = 1'b1;
    settle();
    pulses(12, 2);
    settle();
    exp = to_disp(m_cnt);
    capture(1'b1, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL lc_old_count: got %h expected %h", got, exp); end
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL lc_after_clear: got %h expected %h", got, exp); end
  endtask

  task automatic test_gating();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt; logic [W-1:0] exp;
    do_clear();
    enable = 1'b0;
    settle();
    pulses(50, 2);
    settle();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL gate_disabled: got %h expected %h", got, exp); end
    @(negedge clk) clear_n = 1'b0; enable = 1'b1;
    settle();
    pulses(50, 2);
    settle();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL gate_cleared: got %h expected %h", got, exp); end
    clear_n = 1'b1;
    settle();
  endtask

  task automatic test_reset_mid_window();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt; logic [W-1:0] exp;
    do_clear();
    enable = 1'b1;
    settle();
    pulses(25, 2);
    settle();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rmw_pre: got %h expected %h", got, exp); end
    pulses(5, 2);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    n_cmp++;
    if (count_bcd !== '0) begin n_err++; $display("FAIL rmw_disp_zero: got %h expected 0", count_bcd); end
    settle();
    pulses(7, 2);
    settle();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rmw_post: got %h expected %h", got, exp); end
  endtask

  task automatic test_thousand();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt; logic [W-1:0] exp;
    do_clear();
    enable = 1'b1;
    settle();
    pulses(1000, 2);
    settle();
    exp = to_disp(m_cnt);
    capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL k1000_count: got %h expected %h", got, exp); end
  endtask

  task automatic test_random();
    logic [W-1:0] got; logic got_ovf; int dv_edge, dv_cnt;
    logic [W-1:0] exp; logic exp_ovf;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 3) == 0) do_clear();
      @(negedge clk) enable = 1'($urandom_range(0, 1));
      settle();
      pulses(int'($urandom_range(0, 30)), int'($urandom_range(2, 3)));
      settle();
      enable = 1'b1;
      settle();
      pulses(int'($urandom_range(0, 40)), 2);
      settle();
      exp = to_disp(m_cnt); exp_ovf = m_ovf;
      capture(1'b0, got, got_ovf, dv_edge, dv_cnt);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL rand%0d_count: got %h expected %h", it, got, exp); end
      n_cmp++;
      if (got_ovf !== exp_ovf) begin n_err++; $display("FAIL rand%0d_ovf: got %b expected %b", it, got_ovf, exp_ovf); end
      n_cmp++;
      if (dv_cnt !== 1) begin n_err++; $display("FAIL rand%0d_dv: got %0d pulses expected 1", it, dv_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_count_37();
    test_overflow();
    test_latch_with_clear();
    test_gating();
    test_reset_mid_window();
    test_thousand();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
